// File: rtl/noc_ctrl_pkg.sv
// Shared NoC controller types: sequencer state encoding and default widths.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package noc_ctrl_pkg;

  // Default extents/address widths used by blocks that do not override them.
  localparam int SEQ_DFLT_DIM_WIDTH  = 8;
  localparam int SEQ_DFLT_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/mapper.sv
// Flat address calculator: maps a 4-D index (idx4..idx1) within extents (dim4..dim1) to an offset.
// Latency: combinational; the caller registers the result.
// Backpressure: none; pure function of its inputs.
// Ports: dim4..dim1 extents, idx4..idx1 live indices, addr = offset modulo 2^ADDR_WIDTH.
// ROW_MAJOR=1: idx1 is the fastest-varying address dimension; ROW_MAJOR=0: idx4 is.
module mapper #(
  parameter int DIM4_WIDTH = 8,
  parameter int DIM3_WIDTH = 8,
  parameter int DIM2_WIDTH = 8,
  parameter int DIM1_WIDTH = 8,
  parameter int ROW_MAJOR  = 1,
  parameter int ADDR_WIDTH = 32
) (
  input  logic [DIM4_WIDTH-1:0] dim4,
  input  logic [DIM3_WIDTH-1:0] dim3,
  input  logic [DIM2_WIDTH-1:0] dim2,
  input  logic [DIM1_WIDTH-1:0] dim1,
  input  logic [DIM4_WIDTH-1:0] idx4,
  input  logic [DIM3_WIDTH-1:0] idx3,
  input  logic [DIM2_WIDTH-1:0] idx2,
  input  logic [DIM1_WIDTH-1:0] idx1,
  output logic [ADDR_WIDTH-1:0] addr
);

  // The largest offset is below dim4*dim3*dim2*dim1, so the sum of the extent
  // widths is always enough to hold every intermediate product exactly.
  localparam int PW = DIM4_WIDTH + DIM3_WIDTH + DIM2_WIDTH + DIM1_WIDTH;
  localparam int FW = (PW > ADDR_WIDTH) ? PW : ADDR_WIDTH;

  logic [FW-1:0] full;

  always_comb begin
    full = '0;
    if (ROW_MAJOR != 0) begin
      full = ((FW'(idx4) * FW'(dim3) + FW'(idx3)) * FW'(dim2) + FW'(idx2)) * FW'(dim1)
             + FW'(idx1);
    end else begin
      full = ((FW'(idx1) * FW'(dim2) + FW'(idx2)) * FW'(dim3) + FW'(idx3)) * FW'(dim4)
             + FW'(idx4);
    end
  end

  assign addr = full[ADDR_WIDTH-1:0];

endmodule

// File: rtl/tensor_addr_sequencer.sv
// Walks a 4-D index space (idx1 innermost) and streams one flat address per accepted beat.
// Latency: first beat the cycle after start; one beat/cycle; done pulses the cycle after the last beat.
// Backpressure: addr/addr_last hold while addr_valid && !addr_ready; abort cancels without done.
// Ports: clk/reset (sync, active-high); start/abort control; dim4..dim1 extents sampled on start;
//        addr/addr_valid/addr_ready/addr_last beat stream; busy = RUN; done = completion pulse.
// Optional: SEQ_BASE_ADDR_EN adds a base_addr port, sampled on start and added to every address.
module tensor_addr_sequencer
  import noc_ctrl_pkg::*;
#(
  parameter int DIM4_WIDTH = SEQ_DFLT_DIM_WIDTH,
  parameter int DIM3_WIDTH = SEQ_DFLT_DIM_WIDTH,
  parameter int DIM2_WIDTH = SEQ_DFLT_DIM_WIDTH,
  parameter int DIM1_WIDTH = SEQ_DFLT_DIM_WIDTH,
  parameter int ROW_MAJOR  = 1,
  parameter int ADDR_WIDTH = SEQ_DFLT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DIM4_WIDTH-1:0] dim4,
  input  logic [DIM3_WIDTH-1:0] dim3,
  input  logic [DIM2_WIDTH-1:0] dim2,
  input  logic [DIM1_WIDTH-1:0] dim1,
`ifdef SEQ_BASE_ADDR_EN
  input  logic [ADDR_WIDTH-1:0] base_addr,
`endif
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic                  addr_last,
  output logic                  busy,
  output logic                  done
);

  // One packed tuple type serves both the latched extents and the live indices.
  typedef struct packed {
    logic [DIM4_WIDTH-1:0] n4;
    logic [DIM3_WIDTH-1:0] n3;
    logic [DIM2_WIDTH-1:0] n2;
    logic [DIM1_WIDTH-1:0] n1;
  } coord_t;

  seq_state_t            state_q, state_d;
  coord_t                dims_q, dims_d;
  coord_t                idx_q, idx_d;
  logic                  last_q, last_d;
  logic                  addr_load;
  logic [ADDR_WIDTH-1:0] addr_q, map_addr;
`ifdef SEQ_BASE_ADDR_EN
  logic [ADDR_WIDTH-1:0] base_q, base_d;
`endif

  function automatic logic is_final(input coord_t i, input coord_t d);
    return (i.n1 == d.n1 - DIM1_WIDTH'(1)) && (i.n2 == d.n2 - DIM2_WIDTH'(1)) &&
           (i.n3 == d.n3 - DIM3_WIDTH'(1)) && (i.n4 == d.n4 - DIM4_WIDTH'(1));
  endfunction

  // Odometer step, idx1 fastest. Never called on the final tuple, so idx4 cannot overflow.
  function automatic coord_t step(input coord_t i, input coord_t d);
    coord_t r;
    r = i;
    if (i.n1 != d.n1 - DIM1_WIDTH'(1)) begin
      r.n1 = i.n1 + DIM1_WIDTH'(1);
    end else begin
      r.n1 = '0;
      if (i.n2 != d.n2 - DIM2_WIDTH'(1)) begin
        r.n2 = i.n2 + DIM2_WIDTH'(1);
      end else begin
        r.n2 = '0;
        if (i.n3 != d.n3 - DIM3_WIDTH'(1)) begin
          r.n3 = i.n3 + DIM3_WIDTH'(1);
        end else begin
          r.n3 = '0;
          r.n4 = i.n4 + DIM4_WIDTH'(1);
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    dims_d    = dims_q;
    idx_d     = idx_q;
    last_d    = last_q;
    addr_load = 1'b0;
`ifdef SEQ_BASE_ADDR_EN
    base_d    = base_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((dim4 == '0) || (dim3 == '0) || (dim2 == '0) || (dim1 == '0)) begin
            state_d = DONE;
          end else begin
            dims_d    = '{n4: dim4, n3: dim3, n2: dim2, n1: dim1};
            idx_d     = '0;
            last_d    = is_final('0, dims_d);
            addr_load = 1'b1;
            state_d   = RUN;
`ifdef SEQ_BASE_ADDR_EN
            base_d    = base_addr;
`endif
          end
        end
      end
      RUN: begin
        // Abort takes priority: a beat handshaken in the same cycle is dropped.
        if (abort) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (addr_ready) begin
          if (last_q) begin
            state_d = DONE;
            last_d  = 1'b0;
          end else begin
            idx_d     = step(idx_q, dims_q);
            last_d    = is_final(idx_d, dims_q);
            addr_load = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The mapper sees next-cycle dims/indices so the registered address lines
  // up with the beat it describes.
  mapper #(
    .DIM4_WIDTH(DIM4_WIDTH),
    .DIM3_WIDTH(DIM3_WIDTH),
    .DIM2_WIDTH(DIM2_WIDTH),
    .DIM1_WIDTH(DIM1_WIDTH),
    .ROW_MAJOR (ROW_MAJOR),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mapper (
    .dim4(dims_d.n4),
    .dim3(dims_d.n3),
    .dim2(dims_d.n2),
    .dim1(dims_d.n1),
    .idx4(idx_d.n4),
    .idx3(idx_d.n3),
    .idx2(idx_d.n2),
    .idx1(idx_d.n1),
    .addr(map_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dims_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      addr_q  <= '0;
`ifdef SEQ_BASE_ADDR_EN
      base_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      dims_q  <= dims_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
`ifdef SEQ_BASE_ADDR_EN
      base_q  <= base_d;
      if (addr_load) addr_q <= base_d + map_addr;
`else
      if (addr_load) addr_q <= map_addr;
`endif
    end
  end

  assign addr       = addr_q;
  assign addr_last  = last_q;
  assign addr_valid = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_tensor_addr_sequencer.sv
// Bench for tensor_addr_sequencer: row-major and column-major instances share one stimulus stream.
// Expected beats come from nested-loop enumeration of the index space in traversal order.
module tb_tensor_addr_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, abort, addr_ready;
  logic [7:0]  dim4, dim3, dim2, dim1;
  logic [31:0] base_addr;
  logic [31:0] addr_r, addr_c;
  logic        valid_r, valid_c, last_r, last_c, busy_r, busy_c, done_r, done_c;

  int errors = 0;
  int checks = 0;

  logic [31:0] q_row[$];
  logic [31:0] q_col[$];

  always #5 clk = ~clk;

  tensor_addr_sequencer #(.ROW_MAJOR(1)) dut_row (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .dim4(dim4), .dim3(dim3), .dim2(dim2), .dim1(dim1),
`ifdef SEQ_BASE_ADDR_EN
    .base_addr(base_addr),
`endif
    .addr(addr_r), .addr_valid(valid_r), .addr_ready(addr_ready),
    .addr_last(last_r), .busy(busy_r), .done(done_r)
  );

  tensor_addr_sequencer #(.ROW_MAJOR(0)) dut_col (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .dim4(dim4), .dim3(dim3), .dim2(dim2), .dim1(dim1),
`ifdef SEQ_BASE_ADDR_EN
    .base_addr(base_addr),
`endif
    .addr(addr_c), .addr_valid(valid_c), .addr_ready(addr_ready),
    .addr_last(last_c), .busy(busy_c), .done(done_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Enumerate the index space with idx1 innermost; the row-major address is
  // simply the visit count, the column-major one has idx4 as the unit stride.
  task automatic build(input int d4, input int d3, input int d2, input int d1,
                       input logic [31:0] base);
    int k;
    q_row.delete();
    q_col.delete();
    k = 0;
    for (int i4 = 0; i4 < d4; i4++)
      for (int i3 = 0; i3 < d3; i3++)
        for (int i2 = 0; i2 < d2; i2++)
          for (int i1 = 0; i1 < d1; i1++) begin
            q_row.push_back(base + 32'(k));
            q_col.push_back(base + 32'(i4 + d4 * (i3 + d3 * (i2 + d2 * i1))));
            k++;
          end
  endtask

  task automatic launch(input int d4, input int d3, input int d2, input int d1);
    logic [31:0] b;
`ifdef SEQ_BASE_ADDR_EN
    b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
`else
    b = 32'h0;
`endif
    @(negedge clk);
    dim4 = 8'(d4); dim3 = 8'(d3); dim2 = 8'(d2); dim1 = 8'(d1);
    base_addr = b;
    start = 1'b1;
    build(d4, d3, d2, d1, b);
    @(negedge clk);
    start = 1'b0;
    // Changing the extents after launch must have no effect.
    dim4 = 8'($urandom); dim3 = 8'($urandom); dim2 = 8'($urandom); dim1 = 8'($urandom);
    base_addr = $urandom;
  endtask

  // ready_mode: 0 = always ready, 1 = random ready plus stray starts, 2 = low on valid cycles 1..3.
  task automatic traverse(input int d4, input int d3, input int d2, input int d1,
                          input int ready_mode, input int abort_at);
    int  beats, cyc;
    logic took_last;
    launch(d4, d3, d2, d1);
    if (q_row.size() == 0) begin
      check("zero_done", 32'(done_r), 1);
      check("zero_valid", 32'(valid_r | valid_c), 0);
      @(negedge clk);
      check("zero_done_clr", 32'(done_r), 0);
      check("zero_busy", 32'(busy_r), 0);
      return;
    end
    beats = 0;
    cyc   = 0;
    forever begin
      if (cyc > 4000) begin
        check("beat_budget", 32'(cyc), 32'(4000));
        return;
      end
      check("valid_row", 32'(valid_r), 1);
      check("valid_col", 32'(valid_c), 1);
      check("busy", 32'(busy_r), 1);
      check("done_early", 32'(done_r), 0);
      check("addr_row", addr_r, q_row[0]);
      check("addr_col", addr_c, q_col[0]);
      check("last_row", 32'(last_r), 32'(q_row.size() == 1));
      check("last_col", 32'(last_c), 32'(q_col.size() == 1));
      if (abort_at == beats) begin
        abort = 1'b1;
        addr_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        addr_ready = 1'b0;
        check("abort_busy", 32'(busy_r | busy_c), 0);
        check("abort_valid", 32'(valid_r | valid_c), 0);
        check("abort_done", 32'(done_r | done_c), 0);
        @(negedge clk);
        check("abort_no_done", 32'(done_r | done_c), 0);
        return;
      end
      case (ready_mode)
        0:       addr_ready = 1'b1;
        1:       addr_ready = ($urandom_range(0, 3) != 0);
        default: addr_ready = !(cyc >= 1 && cyc <= 3);
      endcase
      if (ready_mode == 1 && $urandom_range(0, 7) == 0) begin
        start = 1'b1;
        dim1 = 8'($urandom_range(0, 3));
      end
      took_last = 1'b0;
      if (addr_ready) begin
        took_last = (q_row.size() == 1);
        void'(q_row.pop_front());
        void'(q_col.pop_front());
        beats++;
      end
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (took_last) begin
        addr_ready = 1'b0;
        check("done_pulse_row", 32'(done_r), 1);
        check("done_pulse_col", 32'(done_c), 1);
        check("done_valid", 32'(valid_r), 0);
        check("done_busy", 32'(busy_r), 0);
        @(negedge clk);
        check("done_clear", 32'(done_r), 0);
        check("idle_busy", 32'(busy_r), 0);
        return;
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b0;
    dim4 = '0; dim3 = '0; dim2 = '0; dim1 = '0; base_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_addr", addr_r, 0);
    check("rst_valid", 32'(valid_r), 0);
    check("rst_last", 32'(last_r), 0);
    check("rst_busy", 32'(busy_r), 0);
    check("rst_done", 32'(done_r), 0);
    reset = 1'b0;

    traverse(1, 1, 2, 3, 0, -1);   // row 0..5, column 0,2,4,1,3,5
    traverse(1, 1, 1, 4, 2, -1);   // backpressure holds addr 1 for three cycles
    traverse(1, 0, 1, 1, 0, -1);   // zero extent: no beats, immediate done
    traverse(1, 1, 2, 2, 0, 2);    // abort on third beat
    traverse(1, 1, 2, 2, 0, -1);   // restart from 0 after abort
    traverse(1, 1, 1, 1, 1, -1);   // single-beat traversal
    traverse(2, 3, 2, 2, 1, -1);   // all four loops carry

    // Reset in the middle of a traversal returns every output to idle values.
    launch(2, 2, 2, 2);
    addr_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_addr", addr_r, 0);
    check("midrst_valid", 32'(valid_r | valid_c), 0);
    check("midrst_last", 32'(last_r | last_c), 0);
    check("midrst_busy", 32'(busy_r), 0);
    check("midrst_done", 32'(done_r), 0);
    reset = 1'b0;
    addr_ready = 1'b0;

    for (int t = 0; t < 30; t++) begin
      int a4, a3, a2, a1, ab;
      a4 = $urandom_range(1, 3);
      a3 = $urandom_range(1, 3);
      a2 = $urandom_range(1, 4);
      a1 = $urandom_range(1, 4);
      if ($urandom_range(0, 9) == 0) a2 = 0;
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, a4 * a3 * a2 * a1) : -1;
      traverse(a4, a3, a2, a1, 1, ab);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
